regfile_2w2r_sb: RTL and testbench
==================================

Name: regfile_2w2r_sb

Overview:
- Parametrised integer register file for the RV32 core: 2 asynchronous read ports, 2 synchronous write ports (port W0 = ALU writeback, port W1 = load/memory writeback).
- Adds a per-register scoreboard (busy bits) that tracks in-flight producers and raises a read-after-write hazard flag to the pipeline control.
- Sits between decode (read/issue) and writeback stages.

Parameters:
- XLEN, 32, data width of each register.
- NREG, 32, number of architectural registers; AW = $clog2(NREG) is the address width.
- ZERO_REG, 1, when 1 register 0 is hardwired to zero: never written, never marked busy.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- ra_addr  in  AW  read port A address (rs1)
- rb_addr  in  AW  read port B address (rs2)
- ra_data  out  XLEN  read port A data
- rb_data  out  XLEN  read port B data
- w0_en  in  1  write port 0 enable
- w0_addr  in  AW  write port 0 address
- w0_data  in  XLEN  write port 0 data
- w1_en  in  1  write port 1 enable
- w1_addr  in  AW  write port 1 address
- w1_data  in  XLEN  write port 1 data
- iss_valid  in  1  an instruction with a destination is issued this cycle
- iss_rd  in  AW  destination of the issued instruction; marked busy
- hazard  out  1  ra_addr or rb_addr is busy after same-cycle clears
- busy_cnt  out  AW+1  number of registers currently busy

Behaviour:
- Reset (async, rst_n=0): all registers = 0; all busy bits = 0; busy_cnt = 0; hazard = 0. Reset mid-operation discards pending writes and issues immediately.
- Reads: combinational, zero latency. ra_data = reg[ra_addr]. If ZERO_REG=1 and addr=0, the output is 0 regardless of storage.
- Writes: on posedge clk, reg[wX_addr] <= wX_data when wX_en=1. Writes to addr 0 are dropped when ZERO_REG=1.
- Write collision (w0_en and w1_en to the same addr in one cycle): W1 wins; W0 data is discarded.
- Scoreboard: busy[i] is set on posedge when iss_valid=1 and iss_rd=i. It is cleared on posedge when w0_en or w1_en targets i.
- Same cycle set and clear on the same register: set wins (the newer producer is outstanding).
- iss_valid with iss_rd=0 and ZERO_REG=1: ignored.
- A write to a non-busy register is legal; the data is written and busy stays 0.
- hazard (combinational): (busy[ra_addr] and not cleared this cycle) or (busy[rb_addr] and not cleared this cycle). "Cleared this cycle" means a write to that addr is enabled this cycle AND the bypass feature is compiled in. Without the feature, busy alone drives hazard.
- Address 0 never contributes to hazard when ZERO_REG=1.
- busy_cnt: registered population count of busy bits; updates the cycle after a set/clear, +1/-1/0 net per register event. It saturates at NREG (cannot exceed).
- Addresses >= NREG, possible when NREG is not a power of 2: writes ignored, reads return 0, issue ignored.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined: write-first forwarding. If a read address matches an enabled write address in the same cycle, read data = write data (W1 priority over W0), and that register's hazard is suppressed as specified above.
- Not defined: reads return pre-write storage; the hazard stays asserted until the cycle after writeback.

Test Plan:
- Reset then read all addresses -> every ra_data/rb_data = 0; busy_cnt = 0; hazard = 0.
- w0 writes x5=0xDEADBEEF; next cycle ra_addr=5 -> ra_data=0xDEADBEEF. Write x0=0x1234 (ZERO_REG=1) -> reading x0 gives 0.
- Same cycle w0 (x7=0x11111111) and w1 (x7=0x22222222) -> x7 reads 0x22222222.
- Issue rd=3; next cycle ra_addr=3 -> hazard=1, busy_cnt=1. w1 writes x3=0xA5A5A5A5 with ra_addr=3 -> with REGFILE_BYPASS_EN: ra_data=0xA5A5A5A5 and hazard=0 that cycle; without: ra_data=old value and hazard=1. Next cycle: hazard=0, busy_cnt=0.
- Issue rd=9 and w0 write x9 in the same cycle -> busy[9] stays 1, busy_cnt=1, x9 holds the written data.
- Issue rd=4 and rd=6, then assert rst_n=0 asynchronously mid-cycle -> outputs zero immediately; busy_cnt=0, hazard=0.

Source files
------------

// File: rtl/regfile_2w2r_sb.sv
// Two-write / two-read integer register file with a per-register busy scoreboard.
// Define REGFILE_BYPASS_EN for write-first forwarding and same-cycle hazard clearing.
module regfile_2w2r_sb #(
    parameter int unsigned  XLEN     = 32,
    parameter int unsigned  NREG     = 32,
    parameter int unsigned  ZERO_REG = 1,
    localparam int unsigned AW       = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   ra_addr,
    input  logic [AW-1:0]   rb_addr,
    output logic [XLEN-1:0] ra_data,
    output logic [XLEN-1:0] rb_data,
    input  logic            w0_en,
    input  logic [AW-1:0]   w0_addr,
    input  logic [XLEN-1:0] w0_data,
    input  logic            w1_en,
    input  logic [AW-1:0]   w1_addr,
    input  logic [XLEN-1:0] w1_data,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    output logic            hazard,
    output logic [AW:0]     busy_cnt
);

`ifdef REGFILE_BYPASS_EN
    localparam bit Bypass = 1'b1;
`else
    localparam bit Bypass = 1'b0;
`endif

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [NREG-1:0] w0_hit;
    logic [NREG-1:0] w1_hit;
    logic [NREG-1:0] iss_hit;
    logic [NREG-1:0] clr;
    logic [AW:0]     busy_cnt_q;
    logic [AW:0]     busy_cnt_d;
    logic            ra_haz;
    logic            rb_haz;

    // Out-of-range addresses match no implemented register, so they are ignored everywhere.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            w0_hit[i]  = w0_en && (w0_addr == AW'(i));
            w1_hit[i]  = w1_en && (w1_addr == AW'(i));
            iss_hit[i] = iss_valid && (iss_rd == AW'(i));
        end
        if (ZERO_REG != 0) begin
            w0_hit[0]  = 1'b0;
            w1_hit[0]  = 1'b0;
            iss_hit[0] = 1'b0;
        end
        clr = w0_hit | w1_hit;
    end

    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            regs_d[i] = regs_q[i];
            if (w0_hit[i]) regs_d[i] = w0_data;
            if (w1_hit[i]) regs_d[i] = w1_data;
        end
    end

    // A new issue wins over a same-cycle writeback: the newer producer is still outstanding.
    assign busy_d = iss_hit | (busy_q & ~clr);

    always_comb begin
        busy_cnt_d = '0;
        for (int i = 0; i < NREG; i++) begin
            busy_cnt_d = busy_cnt_d + (AW+1)'(busy_d[i]);
        end
        if (32'(busy_cnt_d) > NREG) busy_cnt_d = (AW+1)'(NREG);
    end

    always_comb begin
        ra_data = '0;
        rb_data = '0;
        ra_haz  = 1'b0;
        rb_haz  = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            if (ra_addr == AW'(i)) begin
                ra_data = (Bypass && rst_n) ? regs_d[i] : regs_q[i];
                ra_haz  = busy_q[i] && !(Bypass && clr[i]);
            end
            if (rb_addr == AW'(i)) begin
                rb_data = (Bypass && rst_n) ? regs_d[i] : regs_q[i];
                rb_haz  = busy_q[i] && !(Bypass && clr[i]);
            end
        end
        if (ZERO_REG != 0 && ra_addr == '0) begin
            ra_data = '0;
            ra_haz  = 1'b0;
        end
        if (ZERO_REG != 0 && rb_addr == '0) begin
            rb_data = '0;
            rb_haz  = 1'b0;
        end
    end

    assign hazard   = ra_haz || rb_haz;
    assign busy_cnt = busy_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

`ifndef SYNTHESIS
    a_cnt_matches: assert property (@(posedge clk) disable iff (!rst_n)
        32'(busy_cnt_q) == 32'($countones(busy_q)));
    a_cnt_bound: assert property (@(posedge clk) disable iff (!rst_n)
        32'(busy_cnt_q) <= NREG);
`endif

endmodule

// File: tb/tb_regfile_2w2r_sb.sv
// Randomised and directed bench for regfile_2w2r_sb against an array-based reference model.
// Honours REGFILE_BYPASS_EN the same way as the design build.
module tb_regfile_2w2r_sb;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [AW-1:0]   ra_addr = '0, rb_addr = '0;
    logic [XLEN-1:0] ra_data, rb_data;
    logic            w0_en = 1'b0, w1_en = 1'b0;
    logic [AW-1:0]   w0_addr = '0, w1_addr = '0;
    logic [XLEN-1:0] w0_data = '0, w1_data = '0;
    logic            iss_valid = 1'b0;
    logic [AW-1:0]   iss_rd = '0;
    logic            hazard;
    logic [AW:0]     busy_cnt;

    int tests = 0;
    int fails = 0;

    logic [XLEN-1:0] m_reg [NREG];
    bit              m_busy [NREG];

    regfile_2w2r_sb #(.XLEN(XLEN), .NREG(NREG), .ZERO_REG(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .ra_addr(ra_addr), .rb_addr(rb_addr), .ra_data(ra_data), .rb_data(rb_data),
        .w0_en(w0_en), .w0_addr(w0_addr), .w0_data(w0_data),
        .w1_en(w1_en), .w1_addr(w1_addr), .w1_data(w1_data),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .hazard(hazard), .busy_cnt(busy_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [XLEN-1:0] m_read(input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (BYP && w1_en && w1_addr == a) return w1_data;
        if (BYP && w0_en && w0_addr == a) return w0_data;
        return m_reg[a];
    endfunction

    function automatic logic m_haz(input logic [AW-1:0] a);
        if (a == 0) return 1'b0;
        if (BYP && ((w0_en && w0_addr == a) || (w1_en && w1_addr == a))) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic int m_cnt();
        int n = 0;
        for (int i = 0; i < NREG; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < NREG; i++) begin
            m_reg[i]  = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    task automatic idle();
        w0_en = 1'b0;
        w1_en = 1'b0;
        iss_valid = 1'b0;
    endtask

    // Clock edge plus the model's view of the same edge.
    task automatic tick();
        @(posedge clk);
        if (w0_en && w0_addr != 0) m_reg[w0_addr] = w0_data;
        if (w1_en && w1_addr != 0) m_reg[w1_addr] = w1_data;
        if (w0_en) m_busy[w0_addr] = 1'b0;
        if (w1_en) m_busy[w1_addr] = 1'b0;
        if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        m_clear();
        idle();
        rst_n = 1'b0;
        #12;
        for (int i = 0; i < NREG; i++) begin
            ra_addr = AW'(i);
            rb_addr = AW'(NREG - 1 - i);
            #1;
            tests++;
            if (ra_data !== '0 || rb_data !== '0 || hazard !== 1'b0 || busy_cnt !== '0) begin
                fails++;
                $display("FAIL reset addr %0d: ra=%h rb=%h haz=%b cnt=%0d, required all 0",
                         i, ra_data, rb_data, hazard, busy_cnt);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_write_read();
        w0_en = 1'b1; w0_addr = 5'd5; w0_data = 32'hDEADBEEF;
        tick();
        idle();
        ra_addr = 5'd5;
        #1;
        tests++;
        if (ra_data !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL write_read x5: got %h, required deadbeef", ra_data);
        end
        w0_en = 1'b1; w0_addr = 5'd0; w0_data = 32'h1234;
        tick();
        idle();
        ra_addr = 5'd0;
        rb_addr = 5'd0;
        #1;
        tests++;
        if (ra_data !== '0 || rb_data !== '0) begin
            fails++;
            $display("FAIL zero_reg: ra=%h rb=%h, required 0", ra_data, rb_data);
        end
    endtask

    task automatic test_collision();
        w0_en = 1'b1; w0_addr = 5'd7; w0_data = 32'h11111111;
        w1_en = 1'b1; w1_addr = 5'd7; w1_data = 32'h22222222;
        tick();
        idle();
        rb_addr = 5'd7;
        #1;
        tests++;
        if (rb_data !== 32'h22222222) begin
            fails++;
            $display("FAIL collision x7: got %h, required 22222222", rb_data);
        end
    endtask

    task automatic test_hazard();
        logic [XLEN-1:0] exp_d;
        iss_valid = 1'b1; iss_rd = 5'd3;
        tick();
        idle();
        ra_addr = 5'd3;
        rb_addr = 5'd0;
        #1;
        tests++;
        if (hazard !== 1'b1 || busy_cnt !== 6'd1) begin
            fails++;
            $display("FAIL hazard_set: haz=%b cnt=%0d, required 1/1", hazard, busy_cnt);
        end
        w1_en = 1'b1; w1_addr = 5'd3; w1_data = 32'hA5A5A5A5;
        #1;
        exp_d = BYP ? 32'hA5A5A5A5 : 32'h0;
        tests++;
        if (ra_data !== exp_d || hazard !== !BYP) begin
            fails++;
            $display("FAIL hazard_wb: data=%h haz=%b, required %h/%b",
                     ra_data, hazard, exp_d, !BYP);
        end
        tick();
        idle();
        #1;
        tests++;
        if (hazard !== 1'b0 || busy_cnt !== 6'd0 || ra_data !== 32'hA5A5A5A5) begin
            fails++;
            $display("FAIL hazard_clr: haz=%b cnt=%0d data=%h, required 0/0/a5a5a5a5",
                     hazard, busy_cnt, ra_data);
        end
    endtask

    task automatic test_set_clear();
        iss_valid = 1'b1; iss_rd = 5'd9;
        w0_en = 1'b1; w0_addr = 5'd9; w0_data = 32'hCAFEF00D;
        tick();
        idle();
        ra_addr = 5'd9;
        #1;
        tests++;
        if (busy_cnt !== 6'd1 || hazard !== 1'b1 || ra_data !== 32'hCAFEF00D) begin
            fails++;
            $display("FAIL set_wins: cnt=%0d haz=%b data=%h, required 1/1/cafef00d",
                     busy_cnt, hazard, ra_data);
        end
        w0_en = 1'b1; w0_addr = 5'd9; w0_data = 32'h0BADCAFE;
        tick();
        idle();
        #1;
        tests++;
        if (busy_cnt !== 6'd0 || hazard !== 1'b0 || ra_data !== 32'h0BADCAFE) begin
            fails++;
            $display("FAIL set_clear_done: cnt=%0d haz=%b data=%h, required 0/0/0badcafe",
                     busy_cnt, hazard, ra_data);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            ra_addr   = AW'($urandom_range(0, NREG - 1));
            rb_addr   = AW'($urandom_range(0, NREG - 1));
            w0_en     = ($urandom_range(0, 2) == 0);
            w0_addr   = AW'($urandom_range(0, NREG - 1));
            w0_data   = $urandom;
            w1_en     = ($urandom_range(0, 2) == 0);
            w1_addr   = ($urandom_range(0, 3) == 0) ? w0_addr : AW'($urandom_range(0, NREG - 1));
            w1_data   = $urandom;
            iss_valid = ($urandom_range(0, 1) == 0);
            iss_rd    = ($urandom_range(0, 4) == 0) ? w0_addr : AW'($urandom_range(0, NREG - 1));
            #1;
            tests++;
            if (ra_data !== m_read(ra_addr) || rb_data !== m_read(rb_addr) ||
                hazard !== (m_haz(ra_addr) || m_haz(rb_addr)) ||
                busy_cnt !== (AW+1)'(m_cnt())) begin
                fails++;
                $display("FAIL random #%0d: ra=%h/%h rb=%h/%h haz=%b/%b cnt=%0d/%0d",
                         n, ra_data, m_read(ra_addr), rb_data, m_read(rb_addr),
                         hazard, m_haz(ra_addr) || m_haz(rb_addr), busy_cnt, m_cnt());
            end
            tick();
        end
        idle();
    endtask

    task automatic test_async_reset();
        iss_valid = 1'b1; iss_rd = 5'd4;
        tick();
        iss_rd = 5'd6;
        tick();
        idle();
        ra_addr = 5'd4;
        rb_addr = 5'd6;
        #1;
        tests++;
        if (hazard !== 1'b1 || busy_cnt !== (AW+1)'(m_cnt())) begin
            fails++;
            $display("FAIL pre_reset: haz=%b cnt=%0d, required 1/%0d", hazard, busy_cnt, m_cnt());
        end
        rb_addr = 5'd5;
        #1;
        rst_n = 1'b0;
        m_clear();
        #1;
        tests++;
        if (ra_data !== '0 || rb_data !== '0 || hazard !== 1'b0 || busy_cnt !== '0) begin
            fails++;
            $display("FAIL async_reset: ra=%h rb=%h haz=%b cnt=%0d, required all 0",
                     ra_data, rb_data, hazard, busy_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_collision();
        test_hazard();
        test_set_clear();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
